tristate_bus_arbiter: RTL and testbench

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_arbiter_if.sv | 22 ++
 rtl/tristate_bus_arbiter.sv | 102 ++++++++++
 tb/tb_tristate_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tristate_bus_arbiter_if.sv
// Shared-bus handshake bundle between two requesters and the tri-state bus arbiter.
interface tristate_bus_arbiter_if;
    logic req_0;
    logic req_1;
    logic grant_0;
    logic grant_1;
    logic oe_0;
    logic oe_1;
    logic busy;

    // Requester side: raises requests, observes ownership and drive enables.
    modport master (
        output req_0, req_1,
        input  grant_0, grant_1, oe_0, oe_1, busy
    );

    // Arbiter side.
    modport slave (
        input  req_0, req_1,
        output grant_0, grant_1, oe_0, oe_1, busy
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Two-requester tri-state bus arbiter with burst-limited ownership, round-robin tie
// breaking and a configurable dead (turnaround) gap between owners.
module tristate_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 1,  // 1..15
    parameter int unsigned MAX_BURST   = 16  // 1..256
) (
    input logic                   clk,
    input logic                   rst_n,
    tristate_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StTurn} state_e;

    localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);
    localparam logic [3:0] TurnLoad  = 4'(TURN_CYCLES - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic       grant_0_q, grant_1_q;
    logic       busy_q;
    logic       own_req, other_req;

    // Next-state, round-robin pointer and burst/turnaround counter updates.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        own_req   = (state_q == StOwn1) ? bus.req_1 : bus.req_0;
        other_req = (state_q == StOwn1) ? bus.req_0 : bus.req_1;
        case (state_q)
            StIdle: begin
                // On a tie, requester 0 wins only if requester 1 owned last.
                if (bus.req_0 && (!bus.req_1 || last_q)) begin
                    state_d = StOwn0;
                    last_d  = 1'b0;
                    bcnt_d  = 8'd0;
                end else if (bus.req_1) begin
                    state_d = StOwn1;
                    last_d  = 1'b1;
                    bcnt_d  = 8'd0;
                end
            end
            StOwn0, StOwn1: begin
                if (!own_req || (bcnt_q == BurstLast && other_req)) begin
                    state_d = StTurn;
                    tcnt_d  = TurnLoad;
                end else if (bcnt_q == BurstLast) begin
                    // Nobody waiting: start a fresh burst window for the same owner.
                    bcnt_d = 8'd0;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
            StTurn: begin
                if (tcnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            bcnt_q  <= 8'd0;
            tcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Registered output decodes, so they track state_q exactly and never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_0_q <= 1'b0;
            grant_1_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            grant_0_q <= (state_d == StOwn0);
            grant_1_q <= (state_d == StOwn1);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign bus.grant_0 = grant_0_q;
    assign bus.grant_1 = grant_1_q;
    assign bus.oe_0    = grant_0_q;
    assign bus.oe_1    = grant_1_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed and randomized checks of the tri-state bus arbiter in three configurations.
module tb_tristate_bus_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    tristate_bus_arbiter_if ifa ();  // TURN_CYCLES=1, MAX_BURST=16
    tristate_bus_arbiter_if ifb ();  // TURN_CYCLES=3, MAX_BURST=4
    tristate_bus_arbiter_if ifc ();  // TURN_CYCLES=1, MAX_BURST=4

    tristate_bus_arbiter #(.TURN_CYCLES(1), .MAX_BURST(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    tristate_bus_arbiter #(.TURN_CYCLES(3), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );
    tristate_bus_arbiter #(.TURN_CYCLES(1), .MAX_BURST(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    // Observed output vectors: {grant_0, grant_1, oe_0, oe_1, busy}.
    logic [4:0] obs_a, obs_b, obs_c;
    assign obs_a = {ifa.grant_0, ifa.grant_1, ifa.oe_0, ifa.oe_1, ifa.busy};
    assign obs_b = {ifb.grant_0, ifb.grant_1, ifb.oe_0, ifb.oe_1, ifb.busy};
    assign obs_c = {ifc.grant_0, ifc.grant_1, ifc.oe_0, ifc.oe_1, ifc.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; returns in cycle 0 of a fresh IDLE with all requests low.
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ifa.req_0 = 1'b0; ifa.req_1 = 1'b0;
        ifb.req_0 = 1'b0; ifb.req_1 = 1'b0;
        ifc.req_0 = 1'b0; ifc.req_1 = 1'b0;
    endtask

    task automatic test_reset();
        ifa.req_0 = 1'b1; ifa.req_1 = 1'b1;
        ifb.req_0 = 1'b1; ifb.req_1 = 1'b1;
        ifc.req_0 = 1'b1; ifc.req_1 = 1'b1;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp += 3;
            if (obs_a !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_a cyc%0d: got %b want 00000", k, obs_a);
            end
            if (obs_b !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_b cyc%0d: got %b want 00000", k, obs_b);
            end
            if (obs_c !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_c cyc%0d: got %b want 00000", k, obs_c);
            end
        end
        do_reset();
    endtask

    // Single owner: request at cycle 0, released at cycle 5.
    task automatic test_grant();
        logic [4:0] exp_v;
        logic e0, eb;
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            ifa.req_0 = (k < 5);
            e0 = (k >= 1 && k <= 5);
            eb = (k >= 1 && k <= 6);
            exp_v = {e0, 1'b0, e0, 1'b0, eb};
            n_cmp++;
            if (obs_a !== exp_v) begin
                n_bad++;
                $display("FAIL grant cyc%0d: got %b want %b", k, obs_a, exp_v);
            end
        end
    endtask

    // A one-cycle request still yields exactly one grant cycle.
    task automatic test_pulse();
        logic [4:0] exp_v;
        logic e0, eb;
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) step();
            ifa.req_0 = (k == 0);
            e0 = (k == 1);
            eb = (k == 1 || k == 2);
            exp_v = {e0, 1'b0, e0, 1'b0, eb};
            n_cmp++;
            if (obs_a !== exp_v) begin
                n_bad++;
                $display("FAIL pulse cyc%0d: got %b want %b", k, obs_a, exp_v);
            end
        end
    endtask

    // Lone requester beyond MAX_BURST keeps the bus without a turnaround.
    task automatic test_long_hold();
        logic [4:0] exp_v;
        logic e1, eb;
        do_reset();
        for (int k = 0; k <= 42; k++) begin
            if (k > 0) step();
            ifa.req_1 = (k < 40);
            e1 = (k >= 1 && k <= 40);
            eb = (k >= 1 && k <= 41);
            exp_v = {1'b0, e1, 1'b0, e1, eb};
            n_cmp++;
            if (obs_a !== exp_v) begin
                n_bad++;
                $display("FAIL long_hold cyc%0d: got %b want %b", k, obs_a, exp_v);
            end
        end
    endtask

    // Both held, MAX_BURST=4: 4 owned, 1 TURN, 1 IDLE, alternating, requester 0 first.
    task automatic test_back_to_back();
        logic [4:0] exp_v;
        logic e0, e1, eb;
        int p, half;
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            ifc.req_0 = 1'b1;
            ifc.req_1 = 1'b1;
            if (k == 0) begin
                e0 = 1'b0; e1 = 1'b0; eb = 1'b0;
            end else begin
                p    = (k - 1) % 6;
                half = ((k - 1) / 6) % 2;
                e0 = (p < 4) && (half == 0);
                e1 = (p < 4) && (half == 1);
                eb = (p != 5);
            end
            exp_v = {e0, e1, e0, e1, eb};
            n_cmp++;
            if (obs_c !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", k, obs_c, exp_v);
            end
        end
    endtask

    // Burst window restarts when nobody waits; preemption then follows the restarted count.
    task automatic test_burst_restart();
        logic [4:0] exp_v;
        logic e0, e1, eb;
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            ifc.req_0 = 1'b1;
            ifc.req_1 = (k >= 6);
            e0 = (k >= 1 && k <= 8);
            e1 = (k >= 11);
            eb = (k >= 1 && k != 10);
            exp_v = {e0, e1, e0, e1, eb};
            n_cmp++;
            if (obs_c !== exp_v) begin
                n_bad++;
                $display("FAIL burst_restart cyc%0d: got %b want %b", k, obs_c, exp_v);
            end
        end
    endtask

    // TURN_CYCLES=3: three TURN cycles plus one IDLE; requests raised during TURN wait.
    task automatic test_turnaround();
        logic [4:0] exp_v;
        logic e0, e1, eb;
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) step();
            ifb.req_1 = (k < 3) || (k >= 5);
            ifb.req_0 = (k >= 4);
            e1 = (k >= 1 && k <= 3);
            e0 = (k >= 8);
            eb = (k >= 1 && k <= 6) || (k >= 8);
            exp_v = {e0, e1, e0, e1, eb};
            n_cmp++;
            if (obs_b !== exp_v) begin
                n_bad++;
                $display("FAIL turnaround cyc%0d: got %b want %b", k, obs_b, exp_v);
            end
        end
    endtask

    // Reset mid-burst (OWN1, BCNT=7); afterwards a tie goes to requester 0.
    task automatic test_mid_reset();
        logic [4:0] exp_v;
        logic e0, e1, eb;
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) step();
            if (k == 8) rst_n = 1'b0;
            if (k == 10) rst_n = 1'b1;
            ifa.req_1 = 1'b1;
            ifa.req_0 = (k >= 9);
            e1 = (k >= 1 && k <= 8);
            e0 = (k == 11);
            eb = e0 | e1;
            exp_v = {e0, e1, e0, e1, eb};
            n_cmp++;
            if (obs_a !== exp_v) begin
                n_bad++;
                $display("FAIL mid_reset cyc%0d: got %b want %b", k, obs_a, exp_v);
            end
        end
    endtask

    // Random requests: OE exclusivity and minimum dead gap on every new ownership.
    task automatic test_random();
        logic [2:0] oe0_v, oe1_v;
        int last_owner[3];
        int gap[3];
        int turn_t[3];
        int cur;
        turn_t = '{1, 3, 1};
        last_owner = '{-1, -1, -1};
        gap = '{0, 0, 0};
        do_reset();
        for (int cyc = 0; cyc < 20000; cyc++) begin
            step();
            oe0_v = {ifc.oe_0, ifb.oe_0, ifa.oe_0};
            oe1_v = {ifc.oe_1, ifb.oe_1, ifa.oe_1};
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (oe0_v[i] && oe1_v[i]) begin
                    n_bad++;
                    $display("FAIL rand_excl dut%0d cyc%0d: got oe=11 want not both", i, cyc);
                end else if (oe0_v[i] || oe1_v[i]) begin
                    cur = oe1_v[i] ? 1 : 0;
                    if (last_owner[i] >= 0 && (cur != last_owner[i] || gap[i] > 0)) begin
                        n_cmp++;
                        if (gap[i] < turn_t[i] + 1) begin
                            n_bad++;
                            $display("FAIL rand_gap dut%0d cyc%0d: got gap %0d want >= %0d",
                                     i, cyc, gap[i], turn_t[i] + 1);
                        end
                    end
                    last_owner[i] = cur;
                    gap[i] = 0;
                end else begin
                    gap[i]++;
                end
            end
            if ($urandom_range(0, 7) == 0) ifa.req_0 = ~ifa.req_0;
            if ($urandom_range(0, 7) == 0) ifa.req_1 = ~ifa.req_1;
            if ($urandom_range(0, 7) == 0) ifb.req_0 = ~ifb.req_0;
            if ($urandom_range(0, 7) == 0) ifb.req_1 = ~ifb.req_1;
            if ($urandom_range(0, 7) == 0) ifc.req_0 = ~ifc.req_0;
            if ($urandom_range(0, 7) == 0) ifc.req_1 = ~ifc.req_1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ifa.req_0 = 1'b0; ifa.req_1 = 1'b0;
        ifb.req_0 = 1'b0; ifb.req_1 = 1'b0;
        ifc.req_0 = 1'b0; ifc.req_1 = 1'b0;
        #1;
        test_reset();
        test_grant();
        test_pulse();
        test_long_hold();
        test_back_to_back();
        test_burst_restart();
        test_turnaround();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
